ee457_regfile_wb_arb: RTL and testbench
=======================================

Name: ee457_regfile_wb_arb

Overview:
Write-side controller for the 2-read/1-write register file in the pipelined CPU. It merges two write-back producers onto the single write port (wa/wdata/wen):
- the in-order pipeline WB stage, which has fixed priority and no backpressure;
- a long-latency multiply/divide unit (MDU), connected by valid/ready and buffered in a small FIFO.

It also exports a pending-write scoreboard so decode can stall on buffered results, and requests a pipeline bubble when MDU results starve.

Parameters:
ADDR_SIZE, 5, register address width (32 registers)
DATA_SIZE, 32, register data width
FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (asserted when 0)
pipe_wen  in  1  WB stage write request
pipe_wa  in  ADDR_SIZE  WB stage destination
pipe_wdata  in  DATA_SIZE  WB stage data
mdu_valid  in  1  MDU result valid
mdu_wa  in  ADDR_SIZE  MDU destination
mdu_wdata  in  DATA_SIZE  MDU data
mdu_ready  out  1  buffer can accept this cycle
wen  out  1  register file write enable
wa  out  ADDR_SIZE  register file write address
wdata  out  DATA_SIZE  register file write data
busy  out  2**ADDR_SIZE  bit r=1: a buffered MDU write to r is pending
stall_req  out  1  request one WB bubble to hazard unit

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO is emptied; buffered entries are discarded, including mid-operation.
  - Starve counter is cleared.
  - While rst=0: wen=0, mdu_ready=0, busy=0, stall_req=0, wa=0, wdata=0.
- Pipe write:
  - pipe_wen=1 with pipe_wa!=0 is an effective pipe write.
  - It drives wen=1, wa=pipe_wa, wdata=pipe_wdata combinationally, with zero added latency.
  - pipe_wa=0: no write; treated as an idle pipe slot.
- MDU accept:
  - mdu_ready = (count < FIFO_DEPTH), computed from registered count only.
  - No same-cycle pass-through when full, even if the buffer is draining.
  - A transfer occurs when mdu_valid & mdu_ready.
  - mdu_wa=0: the transfer is consumed but not enqueued.
  - No bypass: an accepted entry is written to the register file at the earliest on the next cycle.
- Drain:
  - When FIFO is non-empty and there is no effective pipe write, the head drives wen=1, wa=head.wa, wdata=head.wdata, and is popped at posedge.
  - FIFO order is strict.
- Simultaneous enqueue and dequeue: count unchanged; order preserved.
- busy:
  - busy[r] = OR over valid FIFO entries with wa==r, decoded from registered state.
  - busy[0] is always 0.
  - A bit clears the cycle after its entry is written.
- WAW between pipe and buffered MDU entries to the same register:
  - Avoided by decode stalling on busy.
  - If it occurs anyway, the pipe write goes first and the FIFO entry is still written later; entries are never cancelled.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and an effective pipe write occurs.
  - It clears on any drain or when the FIFO is empty.
  - stall_req is registered, set when counter == STARVE_LIMIT-1 at posedge, and held until a drain.
  - The hazard unit must present a non-writing WB slot while stall_req=1.
- count width: clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package ee457_cpu_pkg:
  - ADDR_SIZE/DATA_SIZE constants
  - REG_ZERO address constant
  - a wb_req struct {wen, wa, wdata}
- Sub-module ee457_wb_fifo: synchronous FIFO with push/pop/full/empty/count, entries {wa, wdata}, plus a valid-entry vector for the busy decode.
- Arbitration, scoreboard and starve logic stay in the top.

Test Plan:
- Pipe idle; MDU valid with r5=0x12345678 at cycle t -> mdu_ready=1 at t; at t+1, wen=1, wa=5, wdata=0x12345678, busy[5]=1; at t+2, busy=0, wen=0.
- Pipe writes r1..r8 on consecutive cycles; MDU pushes r9=0xA, r10=0xB -> mdu_ready=0 after 2 accepts; stall_req=1 after the 4th blocked cycle; pipe idle one cycle -> r9=0xA written, stall_req=0 next cycle, r10 drains on the following idle cycle.
- Pipe write with pipe_wa=0, data 0xFFFFFFFF -> wen=0. MDU wa=0 accepted -> FIFO count stays 0, busy stays 0.
- count=1 (r3 pending), pipe idle, MDU pushes r4 the same cycle -> r3 written, count stays 1, r4 written the next cycle.
- Two entries buffered, rst=0 for one cycle -> wen=0, mdu_ready=0, busy=0 during reset. After release, mdu_ready=1 and nothing is written.
- Pipe writes r7=0x1 while FIFO head is r7=0x2 -> r7=0x1 written first, r7=0x2 written on the next idle cycle.

Source files
------------

// File: rtl/ee457_cpu_pkg.sv
// Shared CPU constants and the write-back request type used by the
// register-file write-side controller.
package ee457_cpu_pkg;
    localparam int ADDR_SIZE = 5;
    localparam int DATA_SIZE = 32;
    localparam logic [ADDR_SIZE-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 wen;
        logic [ADDR_SIZE-1:0] wa;
        logic [DATA_SIZE-1:0] wdata;
    } wb_req_t;
endpackage

// File: rtl/ee457_wb_fifo.sv
// Small synchronous FIFO buffering MDU write-back results; also exposes
// per-slot valid bits and addresses so the owner can decode pending writes.
module ee457_wb_fifo #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [ADDR_SIZE-1:0]   i_push_wa,
    input  logic [DATA_SIZE-1:0]   i_push_wdata,
    input  logic                   i_pop,
    output logic [ADDR_SIZE-1:0]   o_head_wa,
    output logic [DATA_SIZE-1:0]   o_head_wdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [DEPTH-1:0]       o_valid,
    output logic [ADDR_SIZE-1:0]   o_entry_wa [DEPTH]
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_SIZE-1:0] r_wa    [DEPTH];
    logic [DATA_SIZE-1:0] r_wdata [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]     r_valid;
    logic                 w_full;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_wa[r_wptr]    <= i_push_wa;
            r_wdata[r_wptr] <= i_push_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr          <= r_wptr + 1'b1;
                r_valid[r_wptr] <= 1'b1;
            end
            if (w_do_pop) begin
                r_rptr          <= r_rptr + 1'b1;
                r_valid[r_rptr] <= 1'b0;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_wa    = r_wa[r_rptr];
    assign o_head_wdata = r_wdata[r_rptr];
    assign o_count      = r_count;
    assign o_valid      = r_valid;
    assign o_entry_wa   = r_wa;
endmodule

// File: rtl/ee457_regfile_wb_arb.sv
// Register-file write-port arbiter: WB stage has fixed priority, MDU results
// are buffered and drained in idle slots, with a pending-write scoreboard.
module ee457_regfile_wb_arb
    import ee457_cpu_pkg::wb_req_t, ee457_cpu_pkg::REG_ZERO;
#(
    parameter int ADDR_SIZE    = ee457_cpu_pkg::ADDR_SIZE,
    parameter int DATA_SIZE    = ee457_cpu_pkg::DATA_SIZE,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_wen,
    input  logic [ADDR_SIZE-1:0]    pipe_wa,
    input  logic [DATA_SIZE-1:0]    pipe_wdata,
    input  logic                    mdu_valid,
    input  logic [ADDR_SIZE-1:0]    mdu_wa,
    input  logic [DATA_SIZE-1:0]    mdu_wdata,
    output logic                    mdu_ready,
    output logic                    wen,
    output logic [ADDR_SIZE-1:0]    wa,
    output logic [DATA_SIZE-1:0]    wdata,
    output logic [2**ADDR_SIZE-1:0] busy,
    output logic                    stall_req
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic                    w_pipe_eff;
    logic                    w_ready;
    logic                    w_push;
    logic                    w_drain;
    logic                    w_blocked;
    logic                    w_empty;
    logic [CNT_W-1:0]        w_count;
    logic [ADDR_SIZE-1:0]    w_head_wa;
    logic [DATA_SIZE-1:0]    w_head_wdata;
    logic [FIFO_DEPTH-1:0]   w_valid;
    logic [ADDR_SIZE-1:0]    w_entry_wa [FIFO_DEPTH];
    logic [2**ADDR_SIZE-1:0] w_busy;
    wb_req_t                 w_sel;
    logic [STV_W-1:0]        r_starve;
    logic                    r_stall;

    assign w_pipe_eff = rst && pipe_wen && (pipe_wa != ADDR_SIZE'(REG_ZERO));
    assign w_ready    = rst && (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push     = mdu_valid && w_ready && (mdu_wa != ADDR_SIZE'(REG_ZERO));
    assign w_drain    = rst && !w_empty && !w_pipe_eff;
    assign w_blocked  = rst && !w_empty && w_pipe_eff;

    ee457_wb_fifo #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .i_rst_n      (rst),
        .i_push       (w_push),
        .i_push_wa    (mdu_wa),
        .i_push_wdata (mdu_wdata),
        .i_pop        (w_drain),
        .o_head_wa    (w_head_wa),
        .o_head_wdata (w_head_wdata),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_valid      (w_valid),
        .o_entry_wa   (w_entry_wa)
    );

    always_comb begin
        w_sel = '0;
        if (w_pipe_eff) begin
            w_sel.wen   = 1'b1;
            w_sel.wa    = pipe_wa;
            w_sel.wdata = pipe_wdata;
        end else if (w_drain) begin
            w_sel.wen   = 1'b1;
            w_sel.wa    = w_head_wa;
            w_sel.wdata = w_head_wdata;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_valid[i]) w_busy[w_entry_wa[i]] = 1'b1;
        end
        w_busy[REG_ZERO] = 1'b0;
    end

    // Counter only advances while a buffered result is being starved by the
    // pipe; stall_req stays up until the head actually gets its slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_blocked) begin
                if (r_starve != STV_W'(STARVE_LIMIT)) r_starve <= r_starve + STV_W'(1);
            end else begin
                r_starve <= '0;
            end
            if (w_drain) begin
                r_stall <= 1'b0;
            end else if (w_blocked && (r_starve == STV_W'(STARVE_LIMIT - 1))) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign mdu_ready = w_ready;
    assign wen       = w_sel.wen;
    assign wa        = w_sel.wa;
    assign wdata     = w_sel.wdata;
    assign busy      = rst ? w_busy : '0;
    assign stall_req = rst && r_stall;
endmodule

// File: tb/tb_ee457_regfile_wb_arb.sv
// Directed bench for the register-file write arbiter: per-cycle output checks
// plus an ordered log of every register-file write.
module tb_ee457_regfile_wb_arb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipe_wen = 1'b0;
    logic [AW-1:0] pipe_wa = '0;
    logic [DW-1:0] pipe_wdata = '0;
    logic          mdu_valid = 1'b0;
    logic [AW-1:0] mdu_wa = '0;
    logic [DW-1:0] mdu_wdata = '0;
    logic          mdu_ready;
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wdata;
    logic [31:0]   busy;
    logic          stall_req;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    always #5 clk = ~clk;

    ee457_regfile_wb_arb dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_wen   (pipe_wen),
        .pipe_wa    (pipe_wa),
        .pipe_wdata (pipe_wdata),
        .mdu_valid  (mdu_valid),
        .mdu_wa     (mdu_wa),
        .mdu_wdata  (mdu_wdata),
        .mdu_ready  (mdu_ready),
        .wen        (wen),
        .wa         (wa),
        .wdata      (wdata),
        .busy       (busy),
        .stall_req  (stall_req)
    );

    always @(negedge clk) begin
        if (wen === 1'b1) got_q.push_back({wa, wdata});
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic e_wen, input logic [AW-1:0] e_wa,
                          input logic [DW-1:0] e_wd);
        chk({tag, ".wen"}, 64'(wen), 64'(e_wen));
        chk({tag, ".wa"}, 64'(wa), 64'(e_wa));
        chk({tag, ".wdata"}, 64'(wdata), 64'(e_wd));
    endtask

    task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        pipe_wen   = pw;
        pipe_wa    = pa;
        pipe_wdata = pd;
        mdu_valid  = mv;
        mdu_wa     = ma;
        mdu_wdata  = md;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {a, d};
    endfunction

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        settle();
        chk_wb("rst", 1'b0, '0, '0);
        chk("rst.ready", 64'(mdu_ready), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.stall", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        settle();
        chk("rel.ready", 64'(mdu_ready), 64'd1);
        chk("rel.wen", 64'(wen), 64'd0);

        // single MDU result, pipe idle
        adv(); drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h12345678); settle();
        chk("t1.ready", 64'(mdu_ready), 64'd1);
        chk("t1.wen0", 64'(wen), 64'd0);
        chk("t1.busy0", 64'(busy), 64'd0);
        adv(); idle(); settle();
        chk_wb("t1.drain", 1'b1, 5'd5, 32'h12345678);
        chk("t1.busy1", 64'(busy), 64'h20);
        exp_q.push_back(ent(5'd5, 32'h12345678));
        adv(); idle(); settle();
        chk("t1.busy2", 64'(busy), 64'd0);
        chk("t1.wen2", 64'(wen), 64'd0);

        // pipe hogs the port, MDU buffer fills and starves
        for (int i = 1; i <= 8; i++) begin
            adv();
            if (i == 1)      drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b1, 5'd9, 32'hA);
            else if (i == 2) drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b1, 5'd10, 32'hB);
            else             drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, '0, '0);
            settle();
            chk_wb($sformatf("t2.pipe%0d", i), 1'b1, AW'(i), DW'(32'h100 + i));
            exp_q.push_back(ent(AW'(i), DW'(32'h100 + i)));
            chk($sformatf("t2.stall%0d", i), 64'(stall_req), (i >= 6) ? 64'd1 : 64'd0);
            if (i >= 3) begin
                chk($sformatf("t2.ready%0d", i), 64'(mdu_ready), 64'd0);
                chk($sformatf("t2.busy%0d", i), 64'(busy), 64'h600);
            end
        end
        adv(); idle(); settle();
        chk_wb("t2.r9", 1'b1, 5'd9, 32'hA);
        chk("t2.stall_hold", 64'(stall_req), 64'd1);
        chk("t2.full_drain_ready", 64'(mdu_ready), 64'd0);
        exp_q.push_back(ent(5'd9, 32'hA));
        adv(); idle(); settle();
        chk_wb("t2.r10", 1'b1, 5'd10, 32'hB);
        chk("t2.stall_clr", 64'(stall_req), 64'd0);
        chk("t2.busy_r10", 64'(busy), 64'h400);
        chk("t2.ready1", 64'(mdu_ready), 64'd1);
        exp_q.push_back(ent(5'd10, 32'hB));
        adv(); idle(); settle();
        chk("t2.wen_end", 64'(wen), 64'd0);
        chk("t2.busy_end", 64'(busy), 64'd0);

        // writes to r0 from either side are dropped
        adv(); drive(1'b1, '0, 32'hFFFFFFFF, 1'b1, '0, 32'h55); settle();
        chk("t3.wen", 64'(wen), 64'd0);
        chk("t3.ready", 64'(mdu_ready), 64'd1);
        adv(); idle(); settle();
        chk("t3.wen_next", 64'(wen), 64'd0);
        chk("t3.busy", 64'(busy), 64'd0);

        // simultaneous enqueue and dequeue
        adv(); drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h33); settle();
        chk("t4.wen0", 64'(wen), 64'd0);
        adv(); drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h44); settle();
        chk_wb("t4.r3", 1'b1, 5'd3, 32'h33);
        chk("t4.busy3", 64'(busy), 64'h8);
        chk("t4.ready_a", 64'(mdu_ready), 64'd1);
        exp_q.push_back(ent(5'd3, 32'h33));
        adv(); idle(); settle();
        chk_wb("t4.r4", 1'b1, 5'd4, 32'h44);
        chk("t4.busy4", 64'(busy), 64'h10);
        chk("t4.ready_b", 64'(mdu_ready), 64'd1);
        exp_q.push_back(ent(5'd4, 32'h44));
        adv(); idle(); settle();
        chk("t4.wen_end", 64'(wen), 64'd0);

        // reset discards buffered entries
        adv(); drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC); settle();
        exp_q.push_back(ent(5'd1, 32'h11));
        adv(); drive(1'b1, 5'd2, 32'h12, 1'b1, 5'd13, 32'hD); settle();
        exp_q.push_back(ent(5'd2, 32'h12));
        adv(); drive(1'b1, 5'd3, 32'h13, 1'b0, '0, '0); settle();
        chk("t5.busy_pre", 64'(busy), 64'h3000);
        chk("t5.ready_pre", 64'(mdu_ready), 64'd0);
        exp_q.push_back(ent(5'd3, 32'h13));
        adv(); rst = 1'b0; drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd14, 32'hE); settle();
        chk_wb("t5.rst", 1'b0, '0, '0);
        chk("t5.rst_ready", 64'(mdu_ready), 64'd0);
        chk("t5.rst_busy", 64'(busy), 64'd0);
        chk("t5.rst_stall", 64'(stall_req), 64'd0);
        adv(); rst = 1'b1; idle(); settle();
        chk("t5.ready", 64'(mdu_ready), 64'd1);
        chk("t5.wen", 64'(wen), 64'd0);
        chk("t5.busy", 64'(busy), 64'd0);
        adv(); idle(); settle();
        chk("t5.wen_next", 64'(wen), 64'd0);

        // WAW: pipe goes first, buffered entry still lands later
        adv(); drive(1'b1, 5'd1, 32'h21, 1'b1, 5'd7, 32'h2); settle();
        chk_wb("t6.r1", 1'b1, 5'd1, 32'h21);
        exp_q.push_back(ent(5'd1, 32'h21));
        adv(); drive(1'b1, 5'd7, 32'h1, 1'b0, '0, '0); settle();
        chk_wb("t6.pipe_r7", 1'b1, 5'd7, 32'h1);
        chk("t6.busy7", 64'(busy), 64'h80);
        exp_q.push_back(ent(5'd7, 32'h1));
        adv(); idle(); settle();
        chk_wb("t6.mdu_r7", 1'b1, 5'd7, 32'h2);
        exp_q.push_back(ent(5'd7, 32'h2));
        adv(); idle(); settle();
        chk("t6.wen_end", 64'(wen), 64'd0);
        chk("t6.busy_end", 64'(busy), 64'd0);

        chk("log.size", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("log[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
